// File: rtl/pipelined_max_tree.sv
// Registered binary max/min selection tree: L = clog2(NUM_IN) stages, one vector per cycle, whole pipe freezes while the output is stalled.
// Optional index tracking of the winning channel is enabled by defining PMT_INDEX_EN.
module pipelined_max_tree #(
  parameter  int DATA_W = 12,
  parameter  int NUM_IN = 12,
  parameter  int MODE   = 0,
  localparam int L      = $clog2(NUM_IN),
  localparam int IDX_W  = (L < 1) ? 1 : L
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        data_out
`ifdef PMT_INDEX_EN
  ,
  output logic [IDX_W-1:0]         idx_out
`endif
);

  logic              en;
  logic [L:1]        vld_q;
  logic [L:0]        lvl_vld;
  logic [DATA_W-1:0] lvl_dat [L+1][NUM_IN];
`ifdef PMT_INDEX_EN
  logic [IDX_W-1:0]  lvl_idx [L+1][NUM_IN];
`endif

  assign out_valid = lvl_vld[L];
  assign en        = !(out_valid && !out_ready);
  assign in_ready  = en;
  assign lvl_vld   = {vld_q, in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= lvl_vld[L-1:0];
    end
  end

  for (genvar j = 0; j < NUM_IN; j++) begin : g_in
    assign lvl_dat[0][j] = data_in[j*DATA_W +: DATA_W];
`ifdef PMT_INDEX_EN
    assign lvl_idx[0][j] = IDX_W'(j);
`endif
  end

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int NP = (NUM_IN + (1 << (k - 1)) - 1) >> (k - 1);
    localparam int NC = (NP + 1) / 2;

    for (genvar j = 0; j < NUM_IN; j++) begin : g_node
      if (j < NC) begin : g_used
        logic [DATA_W-1:0] dat_d;
        logic [DATA_W-1:0] dat_q;
`ifdef PMT_INDEX_EN
        logic [IDX_W-1:0]  idx_d;
        logic [IDX_W-1:0]  idx_q;
`endif

        if (2 * j + 1 < NP) begin : g_cmp
          logic [DATA_W-1:0] a;
          logic [DATA_W-1:0] b;
          logic              take_b;
          assign a = lvl_dat[k-1][2*j];
          assign b = lvl_dat[k-1][2*j+1];
          // Strict compare: on a tie the left (lower-index) entry wins.
          assign take_b = (MODE == 1) ? (b < a) : (b > a);
          assign dat_d  = take_b ? b : a;
`ifdef PMT_INDEX_EN
          assign idx_d  = take_b ? lvl_idx[k-1][2*j+1] : lvl_idx[k-1][2*j];
`endif
        end else begin : g_pass
          assign dat_d = lvl_dat[k-1][2*j];
`ifdef PMT_INDEX_EN
          assign idx_d = lvl_idx[k-1][2*j];
`endif
        end

        // Data only loads behind a valid entry, so the output stays 0 until the first result.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dat_q <= '0;
`ifdef PMT_INDEX_EN
            idx_q <= '0;
`endif
          end else if (en && lvl_vld[k-1]) begin
            dat_q <= dat_d;
`ifdef PMT_INDEX_EN
            idx_q <= idx_d;
`endif
          end
        end

        assign lvl_dat[k][j] = dat_q;
`ifdef PMT_INDEX_EN
        assign lvl_idx[k][j] = idx_q;
`endif
      end else begin : g_unused
        assign lvl_dat[k][j] = '0;
`ifdef PMT_INDEX_EN
        assign lvl_idx[k][j] = '0;
`endif
      end
    end
  end

  assign data_out = lvl_dat[L][0];
`ifdef PMT_INDEX_EN
  assign idx_out  = lvl_idx[L][0];
`endif

endmodule
